dcm_freq_meter: RTL and testbench

Receive-side checker for the programmable clock divider: measures the period of an incoming slow clock (10 Hz down to 78.125 mHz, i.e. 10 Hz / 2^k, k = 0..7) against the 100 MHz system clock, decodes it back to the 3-bit program code, and flags loss of lock or disagreement with the divider's reported `prog_out`. It sits beside the divider in the same clock domain and closes the loop on `update`/`prog_in` changes.

---
 rtl/dcm_freq_meter.sv | 216 +++++++++++++++++++++
 tb/tb_dcm_freq_meter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dcm_freq_meter.sv
// dcm_freq_meter: measures the period of a slow clock against clk, decodes it
// to the 3-bit divider code (BASE_PERIOD << k) and reports lock, mismatch
// against the divider's reported code, per-measurement valid/err pulses and
// loss of edges.
// Optional feature macro: DCM_METER_DUTY_EN -- also capture the high time and
// require it to be half the period within TOL.
module dcm_freq_meter #(
  parameter int BASE_PERIOD = 10_000_000,
  parameter int TOL         = 1000,
  parameter int LOCK_N      = 2,
  parameter int CNT_W       = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic [2:0]       expect_prog,
  output logic [2:0]       prog_det,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             err,
  output logic             locked,
  output logic             mismatch,
  output logic             stalled
);

  localparam int LCW = $clog2(LOCK_N + 1);
  localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_N);
  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'((BASE_PERIOD << 7) + TOL);
  localparam logic [CNT_W:0]   TOL_X    = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {IDLE, MEASURE, STALL} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic             stalled_q, stalled_d;
  logic [2:0]       prog_q, prog_d;
  logic [2:0]       cand_q, cand_d;
  logic [LCW-1:0]   lcnt_q, lcnt_d;

  logic             edge_w;
  logic [CNT_W:0]   meas_w;
  logic             match_w;
  logic [2:0]       k_w;
  logic             duty_ok_w;

  // Expected period for code sh, one bit wider than the counter.
  function automatic logic [CNT_W:0] tgt(input int sh);
    return (CNT_W+1)'(BASE_PERIOD) << sh;
  endfunction

  // Unsigned absolute difference without wrap-around.
  function automatic logic [CNT_W:0] absdiff(input logic [CNT_W:0] a, input logic [CNT_W:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Lock counter increment that stops at LOCK_N.
  function automatic logic [LCW-1:0] sat_inc(input logic [LCW-1:0] c);
    return (c >= LOCK_MAX) ? LOCK_MAX : c + 1'b1;
  endfunction

  // Two-stage synchronizer plus one history stage for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[1:0], clk_in};
  end

  assign edge_w = sync_q[1] & ~sync_q[2];
  // Cycles between edges: the counter clears on the cycle after an edge.
  assign meas_w = {1'b0, cnt_q} + 1'b1;

`ifdef DCM_METER_DUTY_EN
  logic [CNT_W-1:0] high_cnt_q;
  logic [CNT_W-1:0] high_q;
  logic             fall_seen_q;
  logic             fall_w;

  assign fall_w = ~sync_q[1] & sync_q[2];

  // High-time counter: restarts at each rising edge, captures at the falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      high_cnt_q  <= '0;
      high_q      <= '0;
      fall_seen_q <= 1'b0;
    end else if (edge_w) begin
      high_cnt_q  <= '0;
      fall_seen_q <= 1'b0;
    end else if (!fall_seen_q) begin
      if (fall_w) begin
        high_q      <= high_cnt_q + 1'b1;
        fall_seen_q <= 1'b1;
      end else if (high_cnt_q != '1) begin
        high_cnt_q  <= high_cnt_q + 1'b1;
      end
    end
  end

  assign duty_ok_w = fall_seen_q &&
                     (absdiff({1'b0, high_q}, meas_w >> 1) <= TOL_X);
`else
  assign duty_ok_w = 1'b1;
`endif

  // Classifier: lowest code whose window contains the measured period.
  always_comb begin
    match_w = 1'b0;
    k_w     = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (absdiff(meas_w, tgt(k)) <= TOL_X) begin
        match_w = 1'b1;
        k_w     = 3'(k);
      end
    end
  end

  // Next-state logic: FSM, period counter, classification and lock tracking.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    locked_d  = locked_q;
    stalled_d = stalled_q;
    prog_d    = prog_q;
    cand_d    = cand_q;
    lcnt_d    = lcnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (edge_w) state_d = MEASURE;
      end
      MEASURE: begin
        if (edge_w) begin
          cnt_d    = '0;
          period_d = meas_w[CNT_W-1:0];
          if (match_w && duty_ok_w) begin
            valid_d = 1'b1;
            lcnt_d  = (k_w == cand_q) ? sat_inc(lcnt_q) : LCW'(1);
            cand_d  = k_w;
            if (lcnt_d == LOCK_MAX) begin
              locked_d = 1'b1;
              prog_d   = k_w;
            end else if (k_w != cand_q) begin
              locked_d = 1'b0;
            end
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            lcnt_d   = '0;
          end
        end else if (cnt_q == TIMEOUT) begin
          state_d   = STALL;
          stalled_d = 1'b1;
          locked_d  = 1'b0;
          lcnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STALL: begin
        cnt_d = '0;
        if (edge_w) begin
          state_d   = MEASURE;
          stalled_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Counter, result and lock registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
      stalled_q <= 1'b0;
      prog_q    <= '0;
      cand_q    <= '0;
      lcnt_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
      stalled_q <= stalled_d;
      prog_q    <= prog_d;
      cand_q    <= cand_d;
      lcnt_q    <= lcnt_d;
    end
  end

  assign prog_det = prog_q;
  assign period   = period_q;
  assign valid    = valid_q;
  assign err      = err_q;
  assign locked   = locked_q;
  assign stalled  = stalled_q;
  assign mismatch = locked_q && (prog_q != expect_prog);

endmodule

// File: tb/tb_dcm_freq_meter.sv
// Testbench for dcm_freq_meter: drives clk_in waveforms with chosen period and
// high time, and compares the DUT against a reference model built from the
// measurement rules (classification windows, run of identical codes for lock).
module tb_dcm_freq_meter;

  localparam int BP      = 100;
  localparam int TOL     = 2;
  localparam int LN      = 2;
  localparam int CW      = 16;
  localparam int TIMEOUT = (BP << 7) + TOL;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_in = 1'b0;
  logic [2:0]    expect_prog = 3'd0;
  logic [2:0]    prog_det;
  logic [CW-1:0] period;
  logic          valid, err, locked, mismatch, stalled;

  dcm_freq_meter #(.BASE_PERIOD(BP), .TOL(TOL), .LOCK_N(LN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clk_in(clk_in), .expect_prog(expect_prog),
    .prog_det(prog_det), .period(period), .valid(valid), .err(err),
    .locked(locked), .mismatch(mismatch), .stalled(stalled)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, nvalid = 0, nerr = 0;
  int last_valid_cyc = 0, stall_cyc = 0;
  logic stalled_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin nvalid++; last_valid_cyc = cyc; end
    if (err) nerr++;
    if (stalled && !stalled_prev) stall_cyc = cyc;
    stalled_prev = stalled;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model state
  int  q[$];
  bit  have_start = 0;
  int  prev_p = 0, prev_h = 0;
  int  m_period = 0, m_prog = 0;
  bit  m_locked = 0;
  int  exp_v, exp_e;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int classify(input int m);
    for (int k = 0; k < 8; k++)
      if (iabs(m - (BP << k)) <= TOL) return k;
    return -1;
  endfunction

  // Locked when the last LN accepted codes since the last break agree.
  function automatic bit run_locked();
    if (q.size() < LN) return 0;
    for (int i = q.size() - LN; i < q.size(); i++)
      if (q[i] != q[q.size()-1]) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    q.delete(); have_start = 0; m_period = 0; m_prog = 0; m_locked = 0;
  endtask

  task automatic model_rise();
    int k;
    bit ok;
    exp_v = 0; exp_e = 0;
    if (!have_start) begin
      have_start = 1;
    end else if (prev_p > TIMEOUT + 1) begin
      q.delete(); m_locked = 0;
    end else begin
      k  = classify(prev_p);
      ok = (k >= 0);
`ifdef DCM_METER_DUTY_EN
      if (ok && iabs(prev_h - prev_p / 2) > TOL) ok = 0;
`endif
      m_period = prev_p;
      if (ok) begin
        exp_v = 1;
        q.push_back(k);
        m_locked = run_locked();
        if (m_locked) m_prog = k;
      end else begin
        exp_e = 1;
        q.delete();
        m_locked = 0;
      end
    end
  endtask

  // One clk_in cycle: rise now, fall after h clk cycles, next rise after p.
  task automatic pulse(input int p, input int h);
    int v0, e0;
    model_rise();
    v0 = nvalid; e0 = nerr;
    clk_in = 1'b1;
    for (int i = 1; i <= p; i++) begin
      @(negedge clk);
      if (i == h) clk_in = 1'b0;
      if (i == 8) begin
        chk("valid_cnt", nvalid - v0, exp_v);
        chk("err_cnt",   nerr - e0, exp_e);
        chk("period",    int'(period), m_period);
        chk("locked",    int'(locked), int'(m_locked));
        chk("prog_det",  int'(prog_det), m_prog);
        chk("mismatch",  int'(mismatch), int'(m_locked && (m_prog != int'(expect_prog))));
        chk("stalled",   int'(stalled), 0);
      end
    end
    chk("pulse_total", (nvalid - v0) + (nerr - e0), exp_v + exp_e);
    prev_p = p; prev_h = h;
  endtask

  initial begin
    int v0, e0, k, reps, p, h;

    // Reset held with clk_in toggling
    rst = 1'b0;
    v0 = nvalid; e0 = nerr;
    for (int i = 0; i < 5; i++) begin
      clk_in = 1'b1; repeat (20) @(negedge clk);
      clk_in = 1'b0; repeat (20) @(negedge clk);
    end
    chk("rst_pulses", (nvalid - v0) + (nerr - e0), 0);
    chk("rst_prog", int'(prog_det), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_mismatch", int'(mismatch), 0);
    chk("rst_stalled", int'(stalled), 0);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);

    // Code 2 lock
    expect_prog = 3'd2;
    repeat (4) pulse(400, 200);
    // Switch to code 0 while divider still reports 2
    repeat (3) pulse(100, 50);
    // Out-of-tolerance period
    repeat (3) pulse(150, 75);
    // Window edges around code 0
    pulse(102, 51); pulse(98, 49); pulse(103, 51); pulse(97, 48); pulse(100, 50);

    // Randomized runs of codes 0..4 with occasional out-of-window jitter
    for (int g = 0; g < 10; g++) begin
      k    = int'($urandom_range(0, 4));
      reps = int'($urandom_range(1, 3));
      expect_prog = ($urandom_range(0, 1) == 1) ? 3'(k) : 3'($urandom_range(0, 7));
      for (int r = 0; r < reps; r++) begin
        p = (BP << k) + int'($urandom_range(0, 6)) - 3;
        h = p / 2 + int'($urandom_range(0, 2)) - 1;
        pulse(p, h);
      end
    end

    // Reset in the middle of a measurement
    pulse(400, 200);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_period", int'(period), 0);
    chk("midrst_prog", int'(prog_det), 0);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    expect_prog = 3'd2;
    repeat (3) pulse(400, 200);

    // Loss of edges: counter clears on the valid cycle, reaches TIMEOUT,
    // and stalled rises on the following cycle.
    pulse(13000, 200);
    chk("stall_delay", stall_cyc - last_valid_cyc, TIMEOUT + 1);
    chk("stall_level", int'(stalled), 1);
    chk("stall_locked", int'(locked), 0);
    m_locked = 0;
    expect_prog = 3'd3;
    repeat (4) pulse(800, 400);

    // Asymmetric duty at period 400
    expect_prog = 3'd2;
    repeat (4) pulse(400, 300);
    pulse(400, 200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
